// File: rtl/led_pwm_pkg.sv
// Shared constants and bus request type for the LED PWM output stage.
package led_pwm_pkg;

  localparam logic [1:0] ADDR_DUTY   = 2'd0;
  localparam logic [1:0] ADDR_BLINK  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_INVERT = 1;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler feeding a free-running frame counter with a wrap strobe.
module led_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_stb
);

  localparam int                PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE = PRE_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick      = run && (pre_cnt == PRE_MAX);
  // Strobe on the tick that wraps pwm_cnt, so consumers latch on the same edge the new frame starts.
  assign frame_stb = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!run) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
      if (tick) pwm_cnt <= pwm_cnt + PWM_ONE;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// LED pin driver: global PWM brightness, blink and polarity with a 4-word Avalon-MM slave.
// Optional gamma-corrected duty when LED_PWM_GAMMA_EN is defined.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int N_LED      = 10,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 50,
  parameter int BLINK_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_LED-1:0] led_in,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [N_LED-1:0] led_pins
);

  localparam logic [BLINK_BITS-1:0] BLINK_ONE = BLINK_BITS'(1);
`ifdef LED_PWM_GAMMA_EN
  localparam logic STATUS_GAMMA = 1'b1;
`else
  localparam logic STATUS_GAMMA = 1'b0;
`endif

  bus_req_t req;
  logic     wr_en, rd_en;

  assign req   = '{cs: chipselect, rd: read, wr: write, addr: address, wdata: writedata};
  assign wr_en = req.cs & req.wr;
  assign rd_en = req.cs & req.rd;

  logic [PWM_BITS-1:0]   duty_reg;
  logic [BLINK_BITS-1:0] blink_reg;
  logic [1:0]            ctrl_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_reg  <= '1;
      blink_reg <= '0;
      ctrl_reg  <= '0;
    end else if (wr_en) begin
      case (req.addr)
        ADDR_DUTY:  duty_reg  <= req.wdata[PWM_BITS-1:0];
        ADDR_BLINK: blink_reg <= req.wdata[BLINK_BITS-1:0];
        ADDR_CTRL:  ctrl_reg  <= req.wdata[1:0];
        default:    ;
      endcase
    end
  end

  logic enable, invert;
  assign enable = ctrl_reg[CTRL_ENABLE];
  assign invert = ctrl_reg[CTRL_INVERT];

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                frame_stb;

  led_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk       (clk),
    .reset     (reset),
    .run       (enable),
    .pwm_cnt   (pwm_cnt),
    .frame_stb (frame_stb)
  );

  logic [PWM_BITS-1:0] duty_next, duty_act;

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  logic                  unused_sq;
  assign duty_sq   = {{PWM_BITS{1'b0}}, duty_reg} * {{PWM_BITS{1'b0}}, duty_reg};
  assign unused_sq = ^duty_sq[PWM_BITS-1:0];
  // Full scale must survive the square so all-ones still means steady on.
  assign duty_next = (&duty_reg) ? '1 : duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_next = duty_reg;
`endif

  // Shadow copy only at frame boundaries so a mid-frame write cannot glitch the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       duty_act <= '1;
    else if (!enable || frame_stb)   duty_act <= duty_next;
  end

  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!enable || blink_reg == '0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_stb) begin
      // >= rather than == so shrinking BLINK below the current count still terminates.
      if (blink_cnt >= blink_reg - BLINK_ONE) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BLINK_ONE;
      end
    end
  end

  logic pwm_on;
  assign pwm_on = (duty_act == '1) || (pwm_cnt < duty_act);

  logic [N_LED-1:0] led_q, on_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_q <= '0;
    else       led_q <= led_in;
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_lane
    assign on_vec[i] = enable & led_q[i] & pwm_on & blink_phase;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_pins <= '0;
    else       led_pins <= on_vec ^ {N_LED{invert}};
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_DUTY:   rd_mux = 32'(duty_reg);
      ADDR_BLINK:  rd_mux = 32'(blink_reg);
      ADDR_CTRL:   rd_mux = 32'(ctrl_reg);
      ADDR_STATUS: rd_mux = {blink_phase, STATUS_GAMMA, 30'(pwm_cnt)};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver at PWM_BITS=4, PRESCALE=2 (32-clk frames).
module tb_led_pwm_driver;

  localparam int N_LED = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N_LED-1:0]  led_in = '0;
  logic              chipselect = 1'b0;
  logic [1:0]        address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [N_LED-1:0]  led_pins;

  int n_assert = 0;
  int n_fail   = 0;

  led_pwm_driver #(
    .N_LED      (N_LED),
    .PWM_BITS   (4),
    .PRESCALE   (2),
    .BLINK_BITS (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .led_in     (led_in),
    .chipselect (chipselect),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_pins   (led_pins)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Samples n cycles starting at the current negedge.
  task automatic count_on(input int n, input logic [N_LED-1:0] pat, output int on, output int bad);
    on = 0; bad = 0;
    for (int i = 0; i < n; i++) begin
      if (led_pins == pat) on++;
      else if (led_pins != '0) bad++;
      @(negedge clk);
    end
  endtask

  // Lands on the first sample where the pins turn on after being off.
  task automatic sync_rise(input string tag);
    int k;
    k = 0;
    while (led_pins != '0 && k < 300) begin @(negedge clk); k++; end
    while (led_pins == '0 && k < 300) begin @(negedge clk); k++; end
    check(tag, 32'(k < 300), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int on1, bad1, on2, bad2;
  logic [31:0] rd;

  initial begin
    idle(3);
    check("reset_pins", 32'(led_pins), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    reset = 1'b0;
    idle(1);

    // Basic PWM at duty 4 of 16
    led_in = 10'h3FF;
    bus_wr(2'd0, 32'd4);
    bus_wr(2'd2, 32'd1);
    idle(40);
    sync_rise("t2_sync");
    count_on(32, 10'h3FF, on1, bad1);
    check("t2_duty4_on", 32'(on1), 32'd8);
    check("t2_duty4_bad", 32'(bad1), 32'd0);
    bus_wr(2'd0, 32'd0);
    idle(64);
    count_on(32, 10'h3FF, on1, bad1);
    check("t2_duty0_on", 32'(on1), 32'd0);
    check("t2_duty0_bad", 32'(bad1), 32'd0);
    bus_wr(2'd0, 32'hF);
    idle(64);
    count_on(32, 10'h3FF, on1, bad1);
    check("t2_dutyF_on", 32'(on1), 32'd32);

    // Mid-frame duty change takes effect only on the next frame
    bus_wr(2'd0, 32'd4);
    idle(64);
    sync_rise("t3_sync");
    fork
      begin
        count_on(32, 10'h3FF, on1, bad1);
        count_on(32, 10'h3FF, on2, bad2);
      end
      begin
        idle(12);
        bus_wr(2'd0, 32'd12);
      end
    join
    check("t3_cur_frame", 32'(on1), 32'd8);
    check("t3_next_frame", 32'(on2), 32'd24);
    check("t3_bad", 32'(bad1 + bad2), 32'd0);

    // Blink every 2 frames
    bus_wr(2'd0, 32'hF);
    led_in = 10'h155;
    idle(40);
    bus_wr(2'd1, 32'd2);
    sync_rise("t4_sync");
    count_on(64, 10'h155, on1, bad1);
    count_on(64, 10'h155, on2, bad2);
    check("t4_phase_on", 32'(on1), 32'd64);
    check("t4_phase_off", 32'(on2), 32'd0);
    check("t4_bad", 32'(bad1 + bad2), 32'd0);
    bus_wr(2'd1, 32'd0);
    idle(4);
    count_on(64, 10'h155, on1, bad1);
    check("t4_blink0_on", 32'(on1), 32'd64);

    // Polarity
    led_in = 10'h001;
    bus_wr(2'd2, 32'd3);
    idle(3);
    check("t5_invert_en", 32'(led_pins), 32'h3FE);
    bus_wr(2'd2, 32'd2);
    idle(2);
    check("t5_invert_dis", 32'(led_pins), 32'h3FF);
    bus_wr(2'd2, 32'd0);
    idle(2);
    check("t5_disabled", 32'(led_pins), 32'h0);

    // Register file behaviour
    bus_wr(2'd0, 32'd4);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'd9;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    check("t6_rw_old", readdata, 32'd4);
    bus_rd(2'd0, rd);
    check("t6_rw_new", rd, 32'd9);
    bus_wr(2'd0, 32'hFFFF_FFF5);
    bus_rd(2'd0, rd);
    check("t6_duty_trunc", rd, 32'h5);
    bus_wr(2'd1, 32'h1234_ABCD);
    bus_rd(2'd1, rd);
    check("t6_blink_trunc", rd, 32'hABCD);
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd3, 32'h1234_5678);
    bus_rd(2'd3, rd);
`ifdef LED_PWM_GAMMA_EN
    check("t6_status", rd, 32'hC000_0000);
`else
    check("t6_status", rd, 32'h8000_0000);
`endif
    idle(3);
    check("t6_readdata_hold", readdata, rd);

    // Reset while running
    bus_wr(2'd0, 32'hF);
    bus_wr(2'd2, 32'd1);
    led_in = 10'h3FF;
    idle(10);
    check("t1_pre_reset_pins", 32'(led_pins), 32'h3FF);
    bus_rd(2'd2, rd);
    check("t1_pre_reset_ctrl", rd, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t1_reset_pins", 32'(led_pins), 32'h0);
    check("t1_reset_readdata", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus_rd(2'd0, rd);
    check("t1_duty", rd, 32'hF);
    bus_rd(2'd1, rd);
    check("t1_blink", rd, 32'h0);
    bus_rd(2'd2, rd);
    check("t1_ctrl", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
